// File: rtl/jt51_seq_pkg.sv
// Shared definitions for the jt51 slot sequencer family.
// Holds the sequencer state encoding and slot-count helper.
package jt51_seq_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] SWEEP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_WAIT  = WAIT,
        ST_SWEEP = SWEEP
    } seq_state_e;

    // Number of {op,ch} slots walked per counter revolution.
    function automatic int slot_count(input int op_w, input int ch_w);
        return 1 << (op_w + ch_w);
    endfunction

endpackage

// File: rtl/jt51_slot_cnt.sv
// Free-running {op,ch} slot counter with registered zero flag
// and combinational wrap flag (cur at last slot).
module jt51_slot_cnt
    import jt51_seq_pkg::*;
#(
    parameter int OP_W = 2,
    parameter int CH_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    output logic [OP_W+CH_W-1:0] cur,
    output logic                 zero,
    output logic                 wrap
);

    localparam int CW = OP_W + CH_W;
    localparam int N  = slot_count(OP_W, CH_W);

    logic [CW-1:0] cur_q;
    logic [CW-1:0] cur_d;
    logic [CW-1:0] nxt;
    logic          zero_q;
    logic          zero_d;

    // Next slot; the natural CW-bit overflow is the N-1 -> 0 wrap.
    always_comb begin
        nxt    = cur_q + CW'(1);
        cur_d  = cur_q;
        zero_d = zero_q;
        if (cen) begin
            cur_d  = nxt;
            zero_d = (nxt == '0);
        end
    end

    // Counter state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            zero_q <= zero_d;
        end
    end

    assign cur  = cur_q;
    assign zero = zero_q;
    assign wrap = (cur_q == CW'(N - 1));

endmodule

// File: rtl/jt51_reg_seq.sv
// Register-write scheduler: accepts one host write, waits for the
// slot wrap, then sweeps all slots issuing per-stage update strobes.
// Optional one-entry queue: define JT51_REG_SEQ_QUEUE_EN.
module jt51_reg_seq
    import jt51_seq_pkg::*;
#(
    parameter int CH_W   = 3,
    parameter int OP_W   = 2,
    parameter int STAGES = 7,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 wr,
    input  logic [OP_W-1:0]      wr_op,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [DW-1:0]        wr_din,
    output logic                 busy,
    output logic                 drop,
    output logic [DW-1:0]        dout,
    output logic [STAGES-1:0]    up_stage,
    output logic [OP_W-1:0]      cur_op,
    output logic [CH_W-1:0]      cur_ch,
    output logic [2**OP_W-1:0]   op_enters,
    output logic                 zero
);

    localparam int CW = OP_W + CH_W;

    logic [CW-1:0] cur;
    logic          wrap;
    logic [CW-1:0] wr_req;
    logic          sweep_end;

    seq_state_e    state_q;
    seq_state_e    state_d;
    logic          busy_q;
    logic          busy_d;
    logic          drop_q;
    logic          drop_d;
    logic [CW-1:0] req_q;
    logic [CW-1:0] req_d;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] dout_d;

`ifdef JT51_REG_SEQ_QUEUE_EN
    logic          q_valid_q;
    logic          q_valid_d;
    logic [CW-1:0] q_req_q;
    logic [CW-1:0] q_req_d;
    logic [DW-1:0] q_din_q;
    logic [DW-1:0] q_din_d;
`endif

    jt51_slot_cnt #(
        .OP_W (OP_W),
        .CH_W (CH_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .cur  (cur),
        .zero (zero),
        .wrap (wrap)
    );

    assign wr_req    = {wr_op, wr_ch};
    assign sweep_end = (state_q == ST_SWEEP) && wrap;

    // Sequencer next state: accept, wait for wrap, sweep, optional requeue.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dout_d  = dout_q;
        drop_d  = drop_q;
`ifdef JT51_REG_SEQ_QUEUE_EN
        q_valid_d = q_valid_q;
        q_req_d   = q_req_q;
        q_din_d   = q_din_q;
`endif
        if (cen) begin
            drop_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (wr) begin
                        state_d = ST_WAIT;
                        req_d   = wr_req;
                        dout_d  = wr_din;
                    end
                end
                ST_WAIT: begin
                    if (wrap) state_d = ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (wrap) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
`ifdef JT51_REG_SEQ_QUEUE_EN
            if (sweep_end && q_valid_q) begin
                state_d   = ST_WAIT;
                req_d     = q_req_q;
                dout_d    = q_din_q;
                q_valid_d = 1'b0;
            end
            if (wr && (state_q != ST_IDLE)) begin
                if (q_valid_q) begin
                    drop_d = 1'b1;
                end else if (sweep_end) begin
                    // Empty queue at sweep end: start the next request directly.
                    state_d = ST_WAIT;
                    req_d   = wr_req;
                    dout_d  = wr_din;
                end else begin
                    q_valid_d = 1'b1;
                    q_req_d   = wr_req;
                    q_din_d   = wr_din;
                end
            end
`else
            if (wr && (state_q != ST_IDLE)) drop_d = 1'b1;
`endif
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            req_q   <= '0;
            dout_q  <= '0;
`ifdef JT51_REG_SEQ_QUEUE_EN
            q_valid_q <= 1'b0;
            q_req_q   <= '0;
            q_din_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
            dout_q  <= dout_d;
`ifdef JT51_REG_SEQ_QUEUE_EN
            q_valid_q <= q_valid_d;
            q_req_q   <= q_req_d;
            q_din_q   <= q_din_d;
`endif
        end
    end

    // Stage k strobes in the sweep slot req+k, wrapping modulo N.
    always_comb begin
        up_stage = '0;
        for (int k = 0; k < STAGES; k++) begin
            up_stage[k] = (state_q == ST_SWEEP) && (cur == req_q + CW'(k));
        end
    end

    // One-hot operator decode of the current slot.
    always_comb begin
        op_enters         = '0;
        op_enters[cur_op] = 1'b1;
    end

    assign cur_op = cur[CW-1:CH_W];
    assign cur_ch = cur[CH_W-1:0];
    assign busy   = busy_q;
    assign drop   = drop_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_jt51_reg_seq.sv
// Self-checking bench for jt51_reg_seq (default and N=64 builds).
// Honours JT51_REG_SEQ_QUEUE_EN when defined for the compile.
module tb_jt51_reg_seq;

    localparam int N  = 32;
    localparam int ST = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cen, wr;
    logic [1:0] wr_op;
    logic [2:0] wr_ch;
    logic [7:0] wr_din;
    logic       busy, drop, zero;
    logic [7:0] dout;
    logic [6:0] up_stage;
    logic [1:0] cur_op;
    logic [2:0] cur_ch;
    logic [3:0] op_enters;

    logic       wr2;
    logic [1:0] op2;
    logic [3:0] ch2;
    logic [7:0] din2;
    logic       busy2, drop2, zero2;
    logic [7:0] dout2;
    logic [2:0] up2;
    logic [1:0] cur_op2;
    logic [3:0] cur_ch2;
    logic [3:0] op_en2;

    jt51_reg_seq #(.CH_W(3), .OP_W(2), .STAGES(7), .DW(8)) dut (
        .clk(clk), .rst(rst), .cen(cen), .wr(wr),
        .wr_op(wr_op), .wr_ch(wr_ch), .wr_din(wr_din),
        .busy(busy), .drop(drop), .dout(dout), .up_stage(up_stage),
        .cur_op(cur_op), .cur_ch(cur_ch), .op_enters(op_enters),
        .zero(zero)
    );

    jt51_reg_seq #(.CH_W(4), .OP_W(2), .STAGES(3), .DW(8)) dut2 (
        .clk(clk), .rst(rst), .cen(cen), .wr(wr2),
        .wr_op(op2), .wr_ch(ch2), .wr_din(din2),
        .busy(busy2), .drop(drop2), .dout(dout2), .up_stage(up2),
        .cur_op(cur_op2), .cur_ch(cur_ch2), .op_enters(op_en2),
        .zero(zero2)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_to(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // Model: t counts cen edges since reset; a request accepted at tick
    // t0 sweeps ticks ts..ts+N-1 with ts the first multiple of N > t0+1.
    longint     t;
    bit         m_active;
    longint     m_ts, m_end;
    int         m_req;
    logic [7:0] m_dout;
    bit         m_drop;
    bit         m_qv;
    int         m_qreq;
    logic [7:0] m_qdin;

    function automatic void acc(input longint t0, input int r,
                                input logic [7:0] d);
        m_req    = r;
        m_dout   = d;
        m_ts     = ((t0 + 1) / N + 1) * N;
        m_end    = m_ts + N;
        m_active = 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            t = 0; m_active = 0; m_drop = 0; m_dout = 0;
            m_req = 0; m_qv = 0; m_ts = 0; m_end = 0;
        end else if (cen) begin
            bit se;
            int wreq;
            wreq = int'({wr_op, wr_ch});
            m_drop = 1'b0;
            if (!m_active) begin
                if (wr) acc(t, wreq, wr_din);
            end else begin
                se = (t == m_end - 1);
`ifdef JT51_REG_SEQ_QUEUE_EN
                begin
                    bit qf;
                    qf = m_qv;
                    if (se && qf) begin
                        acc(t, m_qreq, m_qdin);
                        m_qv = 1'b0;
                    end else if (se) begin
                        m_active = 1'b0;
                    end
                    if (wr) begin
                        if (qf) m_drop = 1'b1;
                        else if (se) acc(t, wreq, wr_din);
                        else begin
                            m_qv = 1'b1; m_qreq = wreq; m_qdin = wr_din;
                        end
                    end
                end
`else
                if (wr) m_drop = 1'b1;
                if (se) m_active = 1'b0;
`endif
            end
            t++;
        end
    end

    function automatic bit in_sweep();
        return m_active && (t >= m_ts) && (t < m_end);
    endfunction

    // Per-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int c;
            logic [6:0] eu;
            c = int'(t % N);
            for (int k = 0; k < ST; k++)
                eu[k] = in_sweep() && (c == (m_req + k) % N);
            chk("cur", {cur_op, cur_ch}, c);
            chk("zero", zero, (t > 0) && (c == 0));
            chk("busy", busy, m_active);
            chk("drop", drop, m_drop);
            chk("dout", dout, m_dout);
            chk("up_stage", up_stage, eu);
            chk("op_enters", op_enters, 4'b0001 << (c >> 3));
        end
    end

    int   fire_cnt[ST] = '{default: 0};
    int   fire_last[ST] = '{default: 0};
    logic [6:0] up_prev = '0;
    int   fire2_cnt[3] = '{default: 0};
    int   fire2_last[3] = '{default: 0};
    logic [2:0] up2_prev = '0;

    // Strobe rise tracking: how often and in which slot each bit fired.
    always @(negedge clk) begin
        for (int k = 0; k < ST; k++) begin
            if (up_stage[k] === 1'b1 && up_prev[k] !== 1'b1) begin
                fire_cnt[k]++;
                fire_last[k] = int'({cur_op, cur_ch});
            end
        end
        up_prev = up_stage;
        for (int k = 0; k < 3; k++) begin
            if (up2[k] === 1'b1 && up2_prev[k] !== 1'b1) begin
                fire2_cnt[k]++;
                fire2_last[k] = int'({cur_op2, cur_ch2});
            end
        end
        up2_prev = up2;
    end

    int base[ST];
    int base2[3];

    task automatic snap();
        for (int k = 0; k < ST; k++) base[k] = fire_cnt[k];
    endtask

    task automatic check_fires(input string nm, input int req, input int n);
        for (int k = 0; k < ST; k++) begin
            chk($sformatf("%s_cnt%0d", nm, k), fire_cnt[k] - base[k], n);
            chk($sformatf("%s_slot%0d", nm, k), fire_last[k], (req + k) % N);
        end
    endtask

    task automatic wait_slot(input string nm, input int v);
        int n = 0;
        while (int'({cur_op, cur_ch}) != v && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) fail_to(nm);
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk); n++;
        end
        if (busy !== 1'b0) fail_to(nm);
    endtask

    task automatic step(input bit w);
        wr = w; cen = 1'b1;
        @(negedge clk);
        cen = 1'b0; wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c0, n, dw;
        int e2[3];
        e2 = '{63, 0, 1};
        rst = 1'b0; cen = 1'b1; wr = 1'b0;
        wr_op = '0; wr_ch = '0; wr_din = '0;
        wr2 = 1'b0; op2 = '0; ch2 = '0; din2 = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cur", {cur_op, cur_ch}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_zero", zero, 0);
        chk("rst_up", up_stage, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_cur", {cur_op, cur_ch}, 1);

        // Write at slot 3 targeting op 3, ch 6, plus two writes while busy.
        wait_slot("to_slot3", 3);
        snap();
        wr = 1'b1; wr_op = 2'd3; wr_ch = 3'd6; wr_din = 8'hA5;
        @(negedge clk);
        wr = 1'b0;
        chk("acc_busy", busy, 1);
        chk("acc_dout", dout, 8'hA5);
        repeat (4) @(negedge clk);
        wr = 1'b1; wr_din = 8'h3C;
        @(negedge clk);
        wr = 1'b0;
`ifdef JT51_REG_SEQ_QUEUE_EN
        chk("q_nodrop", drop, 0);
`else
        chk("busy_drop", drop, 1);
        chk("drop_dout", dout, 8'hA5);
`endif
        repeat (4) @(negedge clk);
        wr = 1'b1; wr_din = 8'h77;
        @(negedge clk);
        wr = 1'b0;
        chk("third_drop", drop, 1);
        wait_idle("t2_idle", 300);
        chk("fall_cur", {cur_op, cur_ch}, 0);
`ifdef JT51_REG_SEQ_QUEUE_EN
        chk("q_dout", dout, 8'h3C);
        check_fires("t2", 30, 2);
`else
        chk("t2_dout", dout, 8'hA5);
        check_fires("t2", 30, 1);
`endif

        // cen one clock in four: slow advance, write at sweep end.
        cen = 1'b0;
        @(negedge clk);
        c0 = int'({cur_op, cur_ch});
        repeat (8) step(1'b0);
        chk("cdiv_8", {cur_op, cur_ch}, (c0 + 8) % N);
        repeat (32) step(1'b0);
        chk("cdiv_32", {cur_op, cur_ch}, (c0 + 8) % N);
        n = 0;
        while (int'({cur_op, cur_ch}) != 10 && n < 64) begin
            step(1'b0); n++;
        end
        if (n >= 64) fail_to("t3_slot10");
        snap();
        wr_op = 2'd0; wr_ch = 3'd5; wr_din = 8'h5A;
        step(1'b1);
        chk("t3_busy", busy, 1);
        chk("t3_dout", dout, 8'h5A);
        n = 0;
        while (!(in_sweep() && (t % N) == 31) && n < 100) begin
            step(1'b0); n++;
        end
        if (n >= 100) fail_to("t3_sweep_end");
        wr_din = 8'h99;
        wr = 1'b1; cen = 1'b1;
        @(negedge clk);
        cen = 1'b0; wr = 1'b0;
        dw = 0;
        for (int i = 0; i < 4; i++) begin
            if (drop === 1'b1) dw++;
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
`ifdef JT51_REG_SEQ_QUEUE_EN
        chk("t3_q_drop_w", dw, 0);
        chk("t3_q_busy", busy, 1);
`else
        chk("t3_drop_w", dw, 4);
        chk("t3_idle", busy, 0);
`endif
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step(1'b0); n++;
        end
        if (busy !== 1'b0) fail_to("t3_idle_wait");
`ifdef JT51_REG_SEQ_QUEUE_EN
        check_fires("t3", 5, 2);
`else
        check_fires("t3", 5, 1);
`endif
        cen = 1'b1;

        // Reset during a sweep, then a fresh write.
        wr_op = 2'd1; wr_ch = 3'd4; wr_din = 8'h11;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        n = 0;
        while (!(in_sweep() && (t % N) == 10) && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) fail_to("t4_slot10");
        snap();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_busy", busy, 0);
        chk("t4_up", up_stage, 0);
        chk("t4_cur", {cur_op, cur_ch}, 0);
        rst = 1'b1;
        @(negedge clk);
        wr_op = 2'd0; wr_ch = 3'd2; wr_din = 8'h66;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        chk("t4_acc_busy", busy, 1);
        chk("t4_acc_dout", dout, 8'h66);
        wait_idle("t4_idle", 200);
        check_fires("t4", 2, 1);

        // N=64 instance: req 63 wraps stage strobes into slots 0 and 1.
        n = 0;
        while (int'({cur_op2, cur_ch2}) != 20 && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) fail_to("t5_slot20");
        for (int k = 0; k < 3; k++) base2[k] = fire2_cnt[k];
        wr2 = 1'b1; op2 = 2'd3; ch2 = 4'd15; din2 = 8'hC3;
        @(negedge clk);
        wr2 = 1'b0;
        chk("t5_busy", busy2, 1);
        chk("t5_dout", dout2, 8'hC3);
        n = 0;
        while (busy2 !== 1'b0 && n < 300) begin
            @(negedge clk); n++;
        end
        if (busy2 !== 1'b0) fail_to("t5_idle");
        chk("t5_fall_cur", {cur_op2, cur_ch2}, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t5_cnt%0d", k), fire2_cnt[k] - base2[k], 1);
            chk($sformatf("t5_slot%0d", k), fire2_last[k], e2[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
